// File: rtl/div32_iter.sv
`default_nettype none
// ============================================================================
// Module      : div32_iter
// Description : Iterative 32-bit signed/unsigned divider. Restoring
//               shift-subtract, one quotient bit per clock, MSB first,
//               33-bit partial remainder, 32 iteration cycles. Results are
//               registered and change only on entry to the DONE state.
//               A zero divisor bypasses iteration and flags div_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module div32_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0]  C_LAST_ITER = 5'd31;
  localparam logic [31:0] C_ALL_ONES  = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;          // iteration index 0..31
  logic [32:0] prem_q, prem_d;        // partial remainder
  logic [31:0] quo_q, quo_d;          // dividend bits shift out, quotient bits shift in
  logic [31:0] dvsr_q, dvsr_d;        // divisor magnitude
  logic        neg_quo_q, neg_quo_d;  // operand signs differ (signed only)
  logic        neg_rem_q, neg_rem_d;  // dividend was negative (signed only)
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;

  // Operand conditioning at acceptance.
  logic        w_accept;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  // One restoring step.
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_fits;
  logic [32:0] w_prem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // A new request is only honoured while not iterating.
  assign w_accept = start && (state_q != S_RUN);
  assign w_a_neg  = signed_op & dividend[31];
  assign w_b_neg  = signed_op & divisor[31];
  // Negating 32'h80000000 yields itself, which is the correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (32'd0 - dividend) : dividend;
  assign w_b_mag  = w_b_neg ? (32'd0 - divisor)  : divisor;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The shifted value is below 2^33, so bit 33 of the difference is the borrow.
  assign w_shift    = {prem_q, quo_q[31]};
  assign w_diff     = w_shift - {2'b00, dvsr_q};
  assign w_fits     = ~w_diff[33];
  assign w_prem_nxt = w_fits ? w_diff[32:0] : w_shift[32:0];
  assign w_quo_nxt  = {quo_q[30:0], w_fits};

  // Truncate-toward-zero sign fix-up applied on the final iteration.
  assign w_quo_fix = neg_quo_q ? (32'd0 - w_quo_nxt)        : w_quo_nxt;
  assign w_rem_fix = neg_rem_q ? (32'd0 - w_prem_nxt[31:0]) : w_prem_nxt[31:0];

  // Next-state, datapath and result computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (divisor == 32'd0) begin
            // No iteration needed: publish the fixed divide-by-zero result.
            state_d     = S_DONE;
            dz_d        = 1'b1;
            quotient_d  = C_ALL_ONES;
            remainder_d = dividend;
          end else begin
            state_d   = S_RUN;
            cnt_d     = 5'd0;
            prem_d    = 33'd0;
            quo_d     = w_a_mag;
            dvsr_d    = w_b_mag;
            neg_quo_d = w_a_neg ^ w_b_neg;
            neg_rem_d = w_a_neg;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        prem_d = w_prem_nxt;
        quo_d  = w_quo_nxt;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == C_LAST_ITER) begin
          state_d     = S_DONE;
          dz_d        = 1'b0;
          quotient_d  = w_quo_fix;
          remainder_d = w_rem_fix;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      prem_q      <= 33'd0;
      quo_q       <= 32'd0;
      dvsr_q      <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
`default_nettype wire

// File: doc/div32_iter.md
DIV32_ITER -- requirements
Module: div32_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled on the rising edge of clk.
REQ-004 SHALL have port signed_op, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-005 SHALL have port dividend, input, 32 bits: numerator; sampled with start.
REQ-006 SHALL have port divisor, input, 32 bits: denominator; sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high while an iteration is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse; results valid in that cycle.
REQ-009 SHALL have port quotient, output, 32 bits: result quotient.
REQ-010 SHALL have port remainder, output, 32 bits: result remainder.
REQ-011 SHALL have port div_zero, output, 1 bit: last accepted operation had divisor == 0.

Function
REQ-012 SHALL implement a three-state FSM (IDLE, RUN, DONE).
- busy = (state == RUN).
- done = (state == DONE).
REQ-013 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on state or results.
REQ-014 SHALL, on acceptance with divisor != 0, capture the operand magnitudes and the sign information, clear the iteration counter, and enter RUN.
- Magnitudes: absolute values if signed_op = 1, else raw values.
REQ-015 SHALL perform restoring shift-subtract, one quotient bit per clock, MSB first, using a 33-bit partial remainder; exactly 32 RUN cycles.
REQ-016 SHALL apply the sign fix-up on the 32nd iteration edge and enter DONE; done SHALL be high in the cycle after the 32nd RUN edge.
- Total latency: 33 edges from the accepting edge.
- Sign fix-up (signed_op = 1): negate the quotient if the operand signs differ; the remainder takes the dividend's sign (truncate toward zero).
REQ-017 SHALL, on acceptance with divisor == 0, skip RUN and enter DONE on the next edge, with:
- div_zero = 1
- quotient = 32'hFFFFFFFF
- remainder = the dividend as captured (unmodified)
REQ-018 SHALL handle signed 32'h80000000 / 32'hFFFFFFFF by wrap-around: quotient = 32'h80000000, remainder = 0, div_zero = 0.
REQ-019 SHALL update quotient, remainder and div_zero only on entry to DONE.
- They hold all other times, including through a subsequent RUN, until the next DONE.
- Accepting a non-zero division SHALL clear div_zero at its DONE.
REQ-020 SHALL transition from DONE to IDLE on the next edge unless start is accepted there, in which case it enters RUN (or DONE for divisor 0) directly.
REQ-021 SHALL leave done low in every cycle other than the single DONE cycle.

Reset
REQ-022 SHALL, while rst = 1, immediately and asynchronously force:
- state = IDLE
- busy = 0, done = 0, div_zero = 0
- quotient = 0, remainder = 0
- internal counter and partial remainder = 0
REQ-023 SHALL abort an in-flight division on rst, with no done pulse; the first start after rst deasserts SHALL behave normally.

Verification
REQ-024 SHALL be verified by each of the following directed scenarios:
- Unsigned: dividend = 100, divisor = 7, signed_op = 0 -> done exactly 33 edges after the accepting edge; quotient = 14, remainder = 2, div_zero = 0; busy high for exactly 32 cycles.
- Signed: dividend = 32'hFFFFFFF9 (-7), divisor = 2, signed_op = 1 -> quotient = 32'hFFFFFFFD (-3), remainder = 32'hFFFFFFFF (-1).
- Divide by zero: dividend = 32'h12345678, divisor = 0 -> done on the edge after acceptance; div_zero = 1, quotient = 32'hFFFFFFFF, remainder = 32'h12345678, busy never high.
- Boundaries:
  - unsigned 32'hFFFFFFFF / 1 -> quotient = 32'hFFFFFFFF, remainder = 0
  - signed 32'h80000000 / 32'hFFFFFFFF -> quotient = 32'h80000000, remainder = 0
  - unsigned 5 / 9 -> quotient = 0, remainder = 5
- Handshake:
  - start with 50 / 5 -> pulse start again at RUN cycle 10 with 9 / 3 -> ignored; results 10 / 0.
  - start 9 / 3 asserted during the DONE cycle -> accepted; second done 33 edges later with 3 / 0.
- Reset mid-operation: assert rst at RUN cycle 10 -> busy, done, quotient, remainder and div_zero all 0 within the same cycle, with no done pulse; after release, 100 / 7 completes with 14 / 2.
